// File: rtl/riscv_core_pkg.sv
// rtl/riscv_core_pkg.sv - shared core types: ROB slot tag width and type
package riscv_core_pkg;

    // 16-entry reorder buffer
    localparam int ROB_SLOT_W = 4;

    typedef logic [ROB_SLOT_W-1:0] rob_slot_t;

endpackage

// File: rtl/riscv_core_fill_fifo.sv
// rtl/riscv_core_fill_fifo.sv - per-port completion FIFO feeding the fill arbiter
module riscv_core_fill_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enq_i,
    input  logic [W-1:0] enq_data_i,
    input  logic         deq_i,
    output logic         rdy_o,
    output logic         nonempty_o,
    output logic [W-1:0] head_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_enq;
    logic          do_deq;

    // Ready looks only at the registered count, never at a same-cycle dequeue
    assign rdy_o      = !reset && (count_q < (PW+1)'(DEPTH));
    assign nonempty_o = (count_q != '0);
    assign head_o     = mem_q[rd_ptr_q];
    assign do_enq     = enq_i && rdy_o;
    assign do_deq     = deq_i && nonempty_o;

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_enq) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + {{PW{1'b0}}, do_enq} - {{PW{1'b0}}, do_deq};
    end

    // Pointer and occupancy state; reset discards everything queued
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem_q[wr_ptr_q] <= enq_data_i;
        end
    end

endmodule

// File: rtl/riscv_core_fill_arbiter.sv
// rtl/riscv_core_fill_arbiter.sv - round-robin completion-to-ROB fill arbiter (option: RISCV_FILL_ARB_OUTREG_EN)
module riscv_core_fill_arbiter
    import riscv_core_pkg::*;
#(
    parameter int NPORTS = 3,
    parameter int DEPTH  = 4,
    parameter int SLOT_W = ROB_SLOT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS-1:0]        fu_cpl_val,
    output logic [NPORTS-1:0]        fu_cpl_rdy,
    input  logic [NPORTS*SLOT_W-1:0] fu_cpl_slot,
    output logic                     rob_fill_val,
    output logic [SLOT_W-1:0]        rob_fill_slot,
    output logic                     fill_busy
);

    localparam int PTR_W = $clog2(NPORTS);

    logic [NPORTS-1:0] nonempty;
    logic [NPORTS-1:0] deq;
    logic [SLOT_W-1:0] heads [NPORTS];

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              gnt_vld;
    logic [PTR_W-1:0]  gnt_idx;
    logic [SLOT_W-1:0] gnt_slot;
    logic [PTR_W:0]    sum;
    logic [PTR_W-1:0]  cand;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        riscv_core_fill_fifo #(
            .DEPTH (DEPTH),
            .W     (SLOT_W)
        ) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .enq_i      (fu_cpl_val[p]),
            .enq_data_i (fu_cpl_slot[p*SLOT_W +: SLOT_W]),
            .deq_i      (deq[p]),
            .rdy_o      (fu_cpl_rdy[p]),
            .nonempty_o (nonempty[p]),
            .head_o     (heads[p])
        );
    end

    // Round-robin search starting at rr_ptr; nothing is granted while in reset
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        cand    = '0;
        for (int i = 0; i < NPORTS; i++) begin
            sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NPORTS)) begin
                cand = PTR_W'(sum - (PTR_W+1)'(NPORTS));
            end else begin
                cand = PTR_W'(sum);
            end
            if (!gnt_vld && nonempty[cand] && !reset) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Dequeue strobe to the winner, granted slot, and next priority pointer
    always_comb begin
        deq      = '0;
        gnt_slot = '0;
        rr_ptr_d = rr_ptr_q;
        if (gnt_vld) begin
            deq[gnt_idx] = 1'b1;
            gnt_slot     = heads[gnt_idx];
            rr_ptr_d     = (gnt_idx == PTR_W'(NPORTS-1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    // Priority pointer moves past the winner, holds when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef RISCV_FILL_ARB_OUTREG_EN
    logic              fill_val_q;
    logic [SLOT_W-1:0] fill_slot_q;

    // Registered fill port: one extra cycle of latency, flop-driven outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_val_q  <= 1'b0;
            fill_slot_q <= '0;
        end else begin
            fill_val_q  <= gnt_vld;
            fill_slot_q <= gnt_slot;
        end
    end

    assign rob_fill_val  = fill_val_q;
    assign rob_fill_slot = fill_slot_q;
    assign fill_busy     = (|nonempty) || fill_val_q;
`else
    assign rob_fill_val  = gnt_vld;
    assign rob_fill_slot = gnt_slot;
    assign fill_busy     = |nonempty;
`endif

endmodule

// File: tb/tb_riscv_core_fill_arbiter.sv
// tb/tb_riscv_core_fill_arbiter.sv - scoreboard bench for the completion fill arbiter
module tb_riscv_core_fill_arbiter;
    import riscv_core_pkg::*;

`ifdef RISCV_FILL_ARB_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  fu_cpl_val = '0;
    logic [2:0]  fu_cpl_rdy;
    logic [11:0] fu_cpl_slot = '0;
    logic        rob_fill_val;
    rob_slot_t   rob_fill_slot;
    logic        fill_busy;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic mute = 1'b0;

    rob_slot_t exp_slot_q [$];
    int        exp_cyc_q [$];
    rob_slot_t mon_s;
    int        mon_c;

    riscv_core_fill_arbiter #(
        .NPORTS (3),
        .DEPTH  (4),
        .SLOT_W (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fu_cpl_val    (fu_cpl_val),
        .fu_cpl_rdy    (fu_cpl_rdy),
        .fu_cpl_slot   (fu_cpl_slot),
        .rob_fill_val  (rob_fill_val),
        .rob_fill_slot (rob_fill_slot),
        .fill_busy     (fill_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input rob_slot_t s, input int c);
        exp_slot_q.push_back(s);
        exp_cyc_q.push_back(c);
    endtask

    // Monitor: every fill must match the oldest expected entry
    always @(negedge clk) begin
        if (!reset && !mute) begin
            if (rob_fill_val) begin
                if (exp_slot_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_fill: got slot %0d at cycle %0d, required no fill", rob_fill_slot, cyc);
                end else begin
                    mon_s = exp_slot_q.pop_front();
                    mon_c = exp_cyc_q.pop_front();
                    chk("fill_slot", int'(rob_fill_slot), int'(mon_s));
                    if (mon_c >= 0) chk("fill_cycle", cyc, mon_c);
                end
            end else begin
                chk("idle_slot_zero", int'(rob_fill_slot), 0);
            end
        end
    end

    task automatic step(input logic [2:0] v, input logic [11:0] s, output logic [2:0] acc, output int c);
        fu_cpl_val  = v;
        fu_cpl_slot = s;
        @(negedge clk);
        acc = v & fu_cpl_rdy;
        c   = cyc;
        @(posedge clk);
        #1;
        fu_cpl_val  = '0;
        fu_cpl_slot = '0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_slot_q.size() != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        n_chk++;
        if (exp_slot_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d fills outstanding, required 0", name, exp_slot_q.size());
            exp_slot_q.delete();
            exp_cyc_q.delete();
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk({name, "_busy_idle"}, int'(fill_busy), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  acc;
        logic [2:0]  low_seen;
        logic [11:0] s;
        int          c;
        int          c0;
        int          sent [3];
        int          iter;

        // 1: reset held for two cycles
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_rdy_low", int'(fu_cpl_rdy), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rdy_high", int'(fu_cpl_rdy), 7);
        chk("rst_fill_val", int'(rob_fill_val), 0);
        chk("rst_fill_slot", int'(rob_fill_slot), 0);
        chk("rst_busy", int'(fill_busy), 0);
        @(posedge clk);
        #1;

        // 2: single completion on port 1
        step(3'b010, {4'd0, 4'd5, 4'd0}, acc, c);
        chk("t2_accept", int'(acc), 2);
        push(4'd5, c + LAT);
        wait_drain("t2");

        // 3: simultaneous completions, rr_ptr restarted at 0
        do_reset(1);
        step(3'b111, {4'd3, 4'd2, 4'd1}, acc, c);
        chk("t3_accept_a", int'(acc), 7);
        push(4'd1, c + LAT);
        push(4'd2, c + LAT + 1);
        push(4'd3, c + LAT + 2);
        step(3'b111, {4'd6, 4'd5, 4'd4}, acc, c0);
        chk("t3_accept_b", int'(acc), 7);
        push(4'd4, c + LAT + 3);
        push(4'd5, c + LAT + 4);
        push(4'd6, c + LAT + 5);
        wait_drain("t3");

        // 4: backpressure, 8 tags per port; grants strictly interleave 0,1,2
        for (int k = 0; k < 24; k++) push(rob_slot_t'(k % 16), -1);
        for (int p = 0; p < 3; p++) sent[p] = 0;
        low_seen = '0;
        iter = 0;
        while ((sent[0] < 8 || sent[1] < 8 || sent[2] < 8) && iter < 200) begin
            s = '0;
            for (int p = 0; p < 3; p++) s[p*4 +: 4] = 4'((3 * sent[p] + p) % 16);
            step({sent[2] < 8, sent[1] < 8, sent[0] < 8}, s, acc, c);
            iter++;
            if (iter == 6) chk("t4_rdy_full", int'(acc), 1);
            low_seen = low_seen | ({sent[2] < 8, sent[1] < 8, sent[0] < 8} & ~acc);
            for (int p = 0; p < 3; p++) if (acc[p]) sent[p]++;
        end
        chk("t4_p0_rdy_dropped", int'(low_seen[0]), 1);
        chk("t4_p1_rdy_dropped", int'(low_seen[1]), 1);
        chk("t4_p2_rdy_dropped", int'(low_seen[2]), 1);
        wait_drain("t4");

        // 5: port 2 alone, ten back-to-back tags across the pointer wrap
        for (int k = 0; k < 10; k++) begin
            s = '0;
            s[11:8] = 4'(k);
            step(3'b100, s, acc, c);
            chk("t5_accept", int'(acc), 4);
            push(rob_slot_t'(k), c + LAT);
        end
        wait_drain("t5");

        // 6: reset mid-burst discards queued completions
        mute = 1'b1;
        step(3'b001, {4'd0, 4'd0, 4'd7}, acc, c);
        step(3'b001, {4'd0, 4'd0, 4'd8}, acc, c);
        step(3'b001, {4'd0, 4'd0, 4'd9}, acc, c);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mute = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t6_no_fill", int'(rob_fill_val), 0);
            chk("t6_busy", int'(fill_busy), 0);
            chk("t6_rdy", int'(fu_cpl_rdy), 7);
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
